// File: rtl/fetch_stage.sv
// fetch_stage: PC, up to two in-flight imem requests, 2-entry return FIFO and IF/ID register.
// FETCH_ALIGN_CHECK_EN: a misaligned redirect target halts fetch and raises fetch_misaligned.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_pype0,
    output logic [31:0] PCp4_pype0,
    output logic [31:0] Instraction_pype,
    output logic        fetch_valid,
    output logic        fetch_misaligned
);
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d, fifo_cnt_q, fifo_cnt_d;
    logic        pcq_head_q, pcq_head_d, fifo_head_q, fifo_head_d;
    logic [31:0] pcq_q [2];
    logic [31:0] pcq_d [2];
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] fifo_inst_q [2];
    logic [31:0] fifo_inst_d [2];
    logic [31:0] if_pc_q, if_pc_d, if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic        halt_q;
    logic        accept, live, bubble, take_fifo, take_live, push;

`ifdef FETCH_ALIGN_CHECK_EN
    logic halt_d;
    always_comb halt_d = redirect ? (redirect_pc[1:0] != 2'b00) : halt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) halt_q <= 1'b0;
        else      halt_q <= halt_d;
    end
`else
    assign halt_q = 1'b0;
`endif

    always_comb begin
        // credit rule: in-flight plus buffered never exceeds the FIFO depth
        imem_req    = !halt_q && !redirect && (({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < 3'd2);
        accept      = imem_req && imem_ready;
        live        = imem_rvalid && !halt_q && (drop_cnt_q == 2'd0);
        bubble      = redirect || nop;
        take_fifo   = !bubble && !keep && (fifo_cnt_q != 2'd0);
        take_live   = !bubble && !keep && (fifo_cnt_q == 2'd0) && live;
        push        = live && !take_live && !redirect;
        fetch_pc_d  = redirect ? (redirect_pc & 32'hFFFF_FFFC) : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
        out_cnt_d   = out_cnt_q + {1'b0, accept} - {1'b0, imem_rvalid};
        drop_cnt_d  = redirect ? out_cnt_q - {1'b0, imem_rvalid}
                               : drop_cnt_q - {1'b0, imem_rvalid && (drop_cnt_q != 2'd0)};
        pcq_d       = pcq_q;
        if (accept) pcq_d[pcq_head_q ^ out_cnt_q[0]] = fetch_pc_q;
        pcq_head_d  = pcq_head_q ^ imem_rvalid;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        if (push) begin
            fifo_pc_d[fifo_head_q ^ fifo_cnt_q[0]]   = pcq_q[pcq_head_q];
            fifo_inst_d[fifo_head_q ^ fifo_cnt_q[0]] = imem_rdata;
        end
        fifo_head_d = fifo_head_q ^ take_fifo;
        fifo_cnt_d  = redirect ? 2'd0 : fifo_cnt_q + {1'b0, push} - {1'b0, take_fifo};
        if_pc_d     = bubble ? 32'd0 : keep ? if_pc_q : take_fifo ? fifo_pc_q[fifo_head_q]
                    : take_live ? pcq_q[pcq_head_q] : 32'd0;
        if_inst_d   = bubble ? NOP_INST : keep ? if_inst_q : take_fifo ? fifo_inst_q[fifo_head_q]
                    : take_live ? imem_rdata : NOP_INST;
        if_valid_d  = bubble ? 1'b0 : keep ? if_valid_q : (take_fifo || take_live);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            out_cnt_q   <= 2'd0;
            drop_cnt_q  <= 2'd0;
            fifo_cnt_q  <= 2'd0;
            pcq_head_q  <= 1'b0;
            fifo_head_q <= 1'b0;
            pcq_q       <= '{32'd0, 32'd0};
            fifo_pc_q   <= '{32'd0, 32'd0};
            fifo_inst_q <= '{32'd0, 32'd0};
            if_pc_q     <= 32'd0;
            if_inst_q   <= NOP_INST;
            if_valid_q  <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            out_cnt_q   <= out_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            fifo_cnt_q  <= fifo_cnt_d;
            pcq_head_q  <= pcq_head_d;
            fifo_head_q <= fifo_head_d;
            pcq_q       <= pcq_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            if_valid_q  <= if_valid_d;
        end
    end

    assign imem_addr        = fetch_pc_q;
    assign PC_pype0         = if_pc_q;
    assign PCp4_pype0       = if_valid_q ? if_pc_q + 32'd4 : 32'd0;
    assign Instraction_pype = if_inst_q;
    assign fetch_valid      = if_valid_q;
    assign fetch_misaligned = halt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against an in-order imem with selectable latency.
module tb_fetch_stage;
    logic        clk = 1'b0, rst = 1'b0, keep = 1'b0, nop = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req, imem_ready = 1'b1, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype;
    logic        fetch_valid, fetch_misaligned;
    int          n_chk = 0, n_pass = 0, lat = 1, cyc = 0;
    logic [31:0] aq[$];
    int          tq[$];
    logic        req_c;
    logic [31:0] addr_c;

    fetch_stage dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PC_pype0(PC_pype0), .PCp4_pype0(PCp4_pype0), .Instraction_pype(Instraction_pype),
        .fetch_valid(fetch_valid), .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h0050_0093 : (a == 32'd4) ? 32'h0010_0113 : (32'hC0DE_0000 | a);
    endfunction

    // request sampled mid-low-phase, well after the negedge-driven controls settle
    always @(negedge clk) begin
        #3;
        req_c  = imem_req;
        addr_c = imem_addr;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aq.delete();
            tq.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'd0;
        end else begin
            cyc = cyc + 1;
            if (req_c && imem_ready) begin
                aq.push_back(addr_c);
                tq.push_back(cyc + lat);
            end
            if (tq.size() > 0 && tq[0] <= cyc + 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= word(aq[0]);
                void'(aq.pop_front());
                void'(tq.pop_front());
            end else begin
                imem_rvalid <= 1'b0;
                imem_rdata  <= 32'hDEAD_BEEF;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check({tag, "_pc"}, PC_pype0, pc);
        check({tag, "_pcp4"}, PCp4_pype0, pc + 32'd4);
        check({tag, "_inst"}, Instraction_pype, inst);
        check({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    endtask

    task automatic is_bubble(input string tag);
        check({tag, "_pc"}, PC_pype0, 32'd0);
        check({tag, "_pcp4"}, PCp4_pype0, 32'd0);
        check({tag, "_inst"}, Instraction_pype, 32'h0000_0013);
        check({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        is_bubble("rst");
        check("rst_mis", {31'd0, fetch_misaligned}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        ifid("first", 32'h0, 32'h0050_0093);
        @(negedge clk);
        ifid("second", 32'h4, 32'h0010_0113);
        @(negedge clk);
        ifid("third", 32'h8, 32'hC0DE_0008);
        check("pre_keep_req", {31'd0, imem_req}, 32'd1);
        check("pre_keep_addr", imem_addr, 32'h10);
        keep = 1'b1;
        @(negedge clk);
        check("keep1_pc", PC_pype0, 32'h8);
        check("keep1_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("keep2_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        ifid("keep3", 32'h8, 32'hC0DE_0008);
        @(negedge clk);
        check("keep4_pc", PC_pype0, 32'h8);
        keep = 1'b0;
        @(negedge clk);
        ifid("drain0", 32'hC, 32'hC0DE_000C);
        @(negedge clk);
        ifid("drain1", 32'h10, 32'hC0DE_0010);
        @(negedge clk);
        ifid("drain2", 32'h14, 32'hC0DE_0014);
        nop = 1'b1;
        @(negedge clk);
        is_bubble("nop");
        check("nop_req", {31'd0, imem_req}, 32'd0);
        nop = 1'b0;
        @(negedge clk);
        ifid("after_nop", 32'h18, 32'hC0DE_0018);
        @(negedge clk);
        ifid("after_nop1", 32'h1C, 32'hC0DE_001C);
        @(negedge clk);
        ifid("after_nop2", 32'h20, 32'hC0DE_0020);
        rst = 1'b0;
        lat = 3;
        #1;
        is_bubble("midrst");
        check("midrst_addr", imem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("two_out_req", {31'd0, imem_req}, 32'd0);
        redirect_pc = 32'h100;
        redirect = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        check("redir_valid", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        check("redir_req", {31'd0, imem_req}, 32'd1);
        check("redir_addr", imem_addr, 32'h100);
        repeat (3) @(negedge clk);
        check("stale_dropped", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        ifid("target", 32'h100, 32'hC0DE_0100);
        redirect_pc = 32'h200;
        redirect = 1'b1;
        keep = 1'b1;
        #1;
        check("redir_cycle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        keep = 1'b0;
        #1;
        is_bubble("combo");
        check("combo_req", {31'd0, imem_req}, 32'd1);
        check("combo_addr", imem_addr, 32'h200);
        repeat (3) @(negedge clk);
        check("combo_drop", {31'd0, fetch_valid}, 32'd0);
        @(negedge clk);
        ifid("combo_target", 32'h200, 32'hC0DE_0200);
        redirect_pc = 32'h102;
        redirect = 1'b1;
        #1;
        check("mis_redir_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
`ifdef FETCH_ALIGN_CHECK_EN
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_mis", {31'd0, fetch_misaligned}, 32'd1);
        @(negedge clk);
        check("halt_hold_req", {31'd0, imem_req}, 32'd0);
        check("halt_hold_mis", {31'd0, fetch_misaligned}, 32'd1);
        redirect_pc = 32'h200;
        redirect = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check("resume_mis", {31'd0, fetch_misaligned}, 32'd0);
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h200);
`else
        check("align_req", {31'd0, imem_req}, 32'd1);
        check("align_addr", imem_addr, 32'h100);
        check("align_mis", {31'd0, fetch_misaligned}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
